clock_ratio_meter: RTL and testbench
====================================

CLOCK_RATIO_METER -- requirements
Module: clock_ratio_meter

Interface
REQ-001 The module SHALL have one clock and one reset: reset is synchronous and active-low, and all state changes only on posedge clock.
REQ-002 Port: clock  input  1  system clock, sole clock domain.
REQ-003 Port: reset  input  1  synchronous active-low reset; reset==0 at a posedge clock resets all state.
REQ-004 Port: clk_in  input  1  divided clock under measurement; asynchronous to clock, and not used as a clock.
REQ-005 Port: timeout_limit  input  32  maximum number of cycles without an edge before timeout; 0 disables timeout.
REQ-006 Port: ratio_ready  input  1  consumer accepts ratio when ratio_valid=1 and ratio_ready=1.
REQ-007 Port: ratio  output  32  measured half-period in clock cycles, which equals the divide ratio driving clk_in.
REQ-008 Port: ratio_valid  output  1  ratio holds an unconsumed measurement.
REQ-009 Port: lock  output  1  the last two captures were equal.
REQ-010 Port: timeout  output  1  no clk_in edge was seen within timeout_limit cycles.
REQ-011 Port: overflow  output  1  sticky: a capture was dropped because the previous ratio was unconsumed.

Function
REQ-012 clk_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3; edge = s2 XOR s3, so both rising and falling edges count.
REQ-013 Cycle counter cnt (32 bit): on an edge cycle, cnt loads 1; otherwise cnt increments, saturating at 0xFFFFFFFF.
REQ-014 FSM states: SEARCH (the reset state), MEASURE, TIMEOUT.
REQ-015 SEARCH: the first edge moves the FSM to MEASURE with no capture.
REQ-016 MEASURE: on each edge, the value of cnt in that cycle is the capture value C; the FSM stays in MEASURE.
REQ-017 Edges spaced N clock cycles apart SHALL give C=N for every N>=1, including N=1.
REQ-018 Output register: a capture loads ratio=C and sets ratio_valid=1 at the end of the edge cycle when ratio_valid=0 or ratio_ready=1.
REQ-019 A capture while ratio_valid=1 and ratio_ready=0 SHALL drop C, leave ratio unchanged and set overflow=1; overflow clears only on reset.
REQ-020 ratio_valid=1 and ratio_ready=1 with no capture SHALL clear ratio_valid on the next cycle.
REQ-021 A simultaneous capture and accept SHALL load the new C and keep ratio_valid=1.
REQ-022 A register prev holds the last C, including dropped captures.
REQ-023 On each capture, lock is set to 1 if C==prev and to 0 otherwise; the first capture after SEARCH or TIMEOUT always gives lock=0.
REQ-024 Timeout: when timeout_limit!=0, the FSM is in SEARCH or MEASURE, there is no edge this cycle and cnt==timeout_limit, the FSM moves to TIMEOUT.
REQ-025 On entering TIMEOUT: timeout=1, lock=0, prev=0; ratio and ratio_valid are unchanged.
REQ-026 TIMEOUT: the next edge moves the FSM to MEASURE with no capture, and clears timeout at the end of that edge cycle.
REQ-027 Latency: ratio and ratio_valid update at the posedge that ends the edge cycle, which is 3 clock cycles after a clk_in transition that is stable at the sampling edge.
REQ-028 An edge and a timeout in the same cycle SHALL resolve as edge wins: no timeout.
REQ-029 While cnt is saturated, no wrap SHALL occur; a capture taken then reports 0xFFFFFFFF.

Reset
REQ-030 With reset==0 at a posedge clock, all of the following SHALL be zero on the next cycle: ratio, ratio_valid, lock, timeout, overflow, cnt, prev, s1, s2 and s3; the FSM SHALL be in SEARCH.
REQ-031 Reset asserted mid-measurement SHALL abandon the measurement; after release, the first edge makes no capture.
REQ-032 ratio_ready and timeout_limit SHALL be ignored while reset==0.

Verification
REQ-033 clk_in toggles every 5 cycles, ratio_ready=1 -> the first capture gives ratio=5 with lock=0; the second capture gives ratio=5 with lock=1; ratio_valid pulses for 1 cycle per capture.
REQ-034 ratio_ready=0 across two captures at N=5 -> ratio stays 5, ratio_valid stays 1, overflow=1; raising ratio_ready then clears ratio_valid on the next cycle.
REQ-035 The period changes from 5 to 7 -> the first capture of 7 gives lock=0; the second capture of 7 gives lock=1.
REQ-036 timeout_limit=100 and clk_in stops -> timeout=1 and lock=0 when cnt==100; toggling resumes every 4 cycles -> timeout clears on the first edge, and the next capture gives ratio=4 with lock=0.
REQ-037 clk_in toggles every cycle (N=1) -> ratio=1 on every capture, then lock=1.
REQ-038 reset=0 for 1 cycle mid-period with ratio_valid=1 -> all outputs read 0 on the next cycle; the first post-reset edge gives no ratio_valid.

Source files
------------

// File: rtl/clock_ratio_meter_if.sv
// Measurement bus for clock_ratio_meter: the clock under test, timeout setting,
// and the ratio/valid/ready handshake with its status flags.
interface clock_ratio_meter_if;
   logic        clk_in;
   logic [31:0] timeout_limit;
   logic        ratio_ready;
   logic [31:0] ratio;
   logic        ratio_valid;
   logic        lock;
   logic        timeout;
   logic        overflow;

   modport master (
      input  clk_in,
      input  timeout_limit,
      input  ratio_ready,
      output ratio,
      output ratio_valid,
      output lock,
      output timeout,
      output overflow
   );

   modport slave (
      output clk_in,
      output timeout_limit,
      output ratio_ready,
      input  ratio,
      input  ratio_valid,
      input  lock,
      input  timeout,
      input  overflow
   );
endinterface

// File: rtl/clock_ratio_meter.sv
// Measures the half-period of an asynchronous divided clock in system clock
// cycles, with lock detection, edge timeout and a ready/valid result register.
module clock_ratio_meter (
   input logic                 clock,
   input logic                 reset,
   clock_ratio_meter_if.master meter
);

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      TIMEOUT
   } state_t;

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   state_t      state;
   logic        s1;
   logic        s2;
   logic        s3;
   logic [31:0] cnt;
   logic [31:0] prev;
   logic [31:0] ratio_q;
   logic        valid_q;
   logic        lock_q;
   logic        timeout_q;
   logic        overflow_q;

   logic        sync_edge;
   logic        capture;
   logic        load;
   logic        timeout_hit;

   // Both clk_in transitions count; a capture is dropped only when the
   // consumer still holds an unaccepted result.
   always_comb begin
      sync_edge   = s2 ^ s3;
      capture     = (state == MEASURE) && sync_edge;
      load        = capture && (!valid_q || meter.ratio_ready);
      timeout_hit = (meter.timeout_limit != 32'd0) && (state != TIMEOUT) &&
                    !sync_edge && (cnt == meter.timeout_limit);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= SEARCH;
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         cnt        <= 32'd0;
         prev       <= 32'd0;
         ratio_q    <= 32'd0;
         valid_q    <= 1'b0;
         lock_q     <= 1'b0;
         timeout_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         s1 <= meter.clk_in;
         s2 <= s1;
         s3 <= s2;

         if (sync_edge) begin
            cnt <= 32'd1;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 32'd1;
         end

         if (load) begin
            ratio_q <= cnt;
            valid_q <= 1'b1;
         end else if (capture) begin
            overflow_q <= 1'b1;
         end else if (valid_q && meter.ratio_ready) begin
            valid_q <= 1'b0;
         end

         // prev is cleared on timeout, so the first capture after it can never lock.
         if (capture) begin
            prev   <= cnt;
            lock_q <= (cnt == prev);
         end

         case (state)
            SEARCH: begin
               if (sync_edge) begin
                  state <= MEASURE;
               end else if (timeout_hit) begin
                  state     <= TIMEOUT;
                  timeout_q <= 1'b1;
                  lock_q    <= 1'b0;
                  prev      <= 32'd0;
               end
            end
            MEASURE: begin
               if (timeout_hit) begin
                  state     <= TIMEOUT;
                  timeout_q <= 1'b1;
                  lock_q    <= 1'b0;
                  prev      <= 32'd0;
               end
            end
            TIMEOUT: begin
               if (sync_edge) begin
                  state     <= MEASURE;
                  timeout_q <= 1'b0;
               end
            end
            default: begin
               state <= SEARCH;
            end
         endcase
      end
   end

   always_comb begin
      meter.ratio       = ratio_q;
      meter.ratio_valid = valid_q;
      meter.lock        = lock_q;
      meter.timeout     = timeout_q;
      meter.overflow    = overflow_q;
   end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter: clk_in is toggled on negedges and the
// results are sampled on negedges at hand-computed offsets.
module tb_clock_ratio_meter;

   logic clock = 1'b0;
   logic reset;

   clock_ratio_meter_if bus ();

   clock_ratio_meter dut (
      .clock (clock),
      .reset (reset),
      .meter (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   logic        v3;
   logic [31:0] r3;
   logic        l3;
   logic        t3;
   logic        o3;
   logic        v4;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Toggle clk_in, sample 3 negedges later (when a capture becomes visible)
   // and once more, then pad so the next toggle lands n cycles after this one.
   task automatic applyStimulus(input int n, output logic v, output logic [31:0] r,
                                output logic l, output logic t, output logic o,
                                output logic v_next);
      bus.clk_in = ~bus.clk_in;
      wait_cycles(3);
      v = bus.ratio_valid;
      r = bus.ratio;
      l = bus.lock;
      t = bus.timeout;
      o = bus.overflow;
      wait_cycles(1);
      v_next = bus.ratio_valid;
      wait_cycles(n - 4);
   endtask

   initial begin
      reset             = 1'b0;
      bus.clk_in        = 1'b0;
      bus.ratio_ready   = 1'b1;
      bus.timeout_limit = 32'd0;
      wait_cycles(3);
      checkOutput("reset_ratio", bus.ratio, 32'd0);
      checkOutput("reset_valid", {31'd0, bus.ratio_valid}, 32'd0);
      checkOutput("reset_lock", {31'd0, bus.lock}, 32'd0);
      checkOutput("reset_timeout", {31'd0, bus.timeout}, 32'd0);
      checkOutput("reset_overflow", {31'd0, bus.overflow}, 32'd0);
      reset = 1'b1;

      // Period 5 with ready held high
      applyStimulus(5, v3, r3, l3, t3, o3, v4);
      checkOutput("n5_first_edge_no_capture", {31'd0, v3}, 32'd0);
      applyStimulus(5, v3, r3, l3, t3, o3, v4);
      checkOutput("n5_cap1_valid", {31'd0, v3}, 32'd1);
      checkOutput("n5_cap1_ratio", r3, 32'd5);
      checkOutput("n5_cap1_lock", {31'd0, l3}, 32'd0);
      checkOutput("n5_cap1_pulse", {31'd0, v4}, 32'd0);
      applyStimulus(5, v3, r3, l3, t3, o3, v4);
      checkOutput("n5_cap2_ratio", r3, 32'd5);
      checkOutput("n5_cap2_lock", {31'd0, l3}, 32'd1);
      checkOutput("n5_cap2_pulse", {31'd0, v4}, 32'd0);

      // Consumer stalls across two captures
      bus.ratio_ready = 1'b0;
      applyStimulus(5, v3, r3, l3, t3, o3, v4);
      checkOutput("stall_cap_valid", {31'd0, v3}, 32'd1);
      checkOutput("stall_no_overflow_yet", {31'd0, o3}, 32'd0);
      checkOutput("stall_valid_held", {31'd0, v4}, 32'd1);
      applyStimulus(5, v3, r3, l3, t3, o3, v4);
      checkOutput("stall_drop_overflow", {31'd0, o3}, 32'd1);
      checkOutput("stall_drop_ratio", r3, 32'd5);
      checkOutput("stall_drop_valid", {31'd0, v3}, 32'd1);
      bus.ratio_ready = 1'b1;
      wait_cycles(1);
      checkOutput("stall_release_clears_valid", {31'd0, bus.ratio_valid}, 32'd0);

      // Period change: gap of 6 (stall release cycle) then 7, 7
      applyStimulus(7, v3, r3, l3, t3, o3, v4);
      checkOutput("gap6_ratio", r3, 32'd6);
      checkOutput("gap6_lock", {31'd0, l3}, 32'd0);
      applyStimulus(7, v3, r3, l3, t3, o3, v4);
      checkOutput("n7_cap1_ratio", r3, 32'd7);
      checkOutput("n7_cap1_lock", {31'd0, l3}, 32'd0);
      applyStimulus(7, v3, r3, l3, t3, o3, v4);
      checkOutput("n7_cap2_ratio", r3, 32'd7);
      checkOutput("n7_cap2_lock", {31'd0, l3}, 32'd1);
      checkOutput("overflow_sticky", {31'd0, o3}, 32'd1);

      // clk_in stops: the last edge reaches cnt==100 103 negedges after its toggle
      bus.timeout_limit = 32'd100;
      wait_cycles(95);
      checkOutput("timeout_not_early", {31'd0, bus.timeout}, 32'd0);
      wait_cycles(1);
      checkOutput("timeout_set", {31'd0, bus.timeout}, 32'd1);
      checkOutput("timeout_lock_clear", {31'd0, bus.lock}, 32'd0);
      checkOutput("timeout_ratio_kept", bus.ratio, 32'd7);

      // Resume at period 4
      applyStimulus(4, v3, r3, l3, t3, o3, v4);
      checkOutput("resume_timeout_clear", {31'd0, t3}, 32'd0);
      checkOutput("resume_no_capture", {31'd0, v3}, 32'd0);
      applyStimulus(4, v3, r3, l3, t3, o3, v4);
      checkOutput("resume_ratio", r3, 32'd4);
      checkOutput("resume_lock", {31'd0, l3}, 32'd0);
      applyStimulus(4, v3, r3, l3, t3, o3, v4);
      checkOutput("resume_lock2", {31'd0, l3}, 32'd1);

      // timeout_limit equals the period: the edge cycle must win
      bus.timeout_limit = 32'd4;
      applyStimulus(4, v3, r3, l3, t3, o3, v4);
      checkOutput("edge_wins_timeout", {31'd0, t3}, 32'd0);
      checkOutput("edge_wins_ratio", r3, 32'd4);
      checkOutput("edge_wins_lock", {31'd0, l3}, 32'd1);
      applyStimulus(4, v3, r3, l3, t3, o3, v4);
      checkOutput("edge_wins_timeout2", {31'd0, t3}, 32'd0);
      bus.timeout_limit = 32'd0;

      // N=1: toggle every cycle; iteration i shows the result of toggle i-2
      for (int i = 0; i < 13; i++) begin
         bus.clk_in = ~bus.clk_in;
         wait_cycles(1);
         if (i == 2) begin
            checkOutput("n1_gap4_ratio", bus.ratio, 32'd4);
            checkOutput("n1_gap4_lock", {31'd0, bus.lock}, 32'd1);
         end
         if (i == 3) begin
            checkOutput("n1_first_ratio", bus.ratio, 32'd1);
            checkOutput("n1_first_lock", {31'd0, bus.lock}, 32'd0);
         end
         if (i == 5) begin
            checkOutput("n1_valid_kept", {31'd0, bus.ratio_valid}, 32'd1);
            checkOutput("n1_lock", {31'd0, bus.lock}, 32'd1);
         end
         if (i == 12) begin
            checkOutput("n1_last_ratio", bus.ratio, 32'd1);
            checkOutput("n1_last_lock", {31'd0, bus.lock}, 32'd1);
         end
      end

      // Hold a result, then pulse reset for one cycle
      bus.ratio_ready = 1'b0;
      wait_cycles(3);
      checkOutput("pre_reset_valid", {31'd0, bus.ratio_valid}, 32'd1);
      reset = 1'b0;
      wait_cycles(1);
      reset = 1'b1;
      checkOutput("mid_reset_ratio", bus.ratio, 32'd0);
      checkOutput("mid_reset_valid", {31'd0, bus.ratio_valid}, 32'd0);
      checkOutput("mid_reset_lock", {31'd0, bus.lock}, 32'd0);
      checkOutput("mid_reset_timeout", {31'd0, bus.timeout}, 32'd0);
      checkOutput("mid_reset_overflow", {31'd0, bus.overflow}, 32'd0);
      bus.ratio_ready = 1'b1;
      applyStimulus(5, v3, r3, l3, t3, o3, v4);
      checkOutput("post_reset_no_capture", {31'd0, v3}, 32'd0);
      applyStimulus(5, v3, r3, l3, t3, o3, v4);
      checkOutput("post_reset_valid", {31'd0, v3}, 32'd1);
      checkOutput("post_reset_ratio", r3, 32'd5);
      checkOutput("post_reset_lock", {31'd0, l3}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
